ex_flags_stage: RTL and testbench
=================================

EX_FLAGS_STAGE -- requirements
Module: ex_flags_stage

Interface
REQ-001 Parameter: WIDTH, 64, datapath width of the ALU result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 alu_result  input  WIDTH  ALU result for the instruction in EX.
REQ-005 alu_negative, alu_zero, alu_overflow, alu_carry  input  1 each  ALU flags for the same instruction.
REQ-006 valid_in  input  1  EX holds a real instruction.
REQ-007 set_flags  input  1  instruction is flag-setting (ADDS/SUBS class).
REQ-008 br_type  input  2  00 none, 01 unconditional B, 10 CBZ, 11 B.cond.
REQ-009 cond  input  4  B.cond code: 0 EQ, 1 NE, 2 HS, 3 LO, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, A GE, B LT, C GT, D LE, E/F AL.
REQ-010 stall  input  1  hold all stage state this cycle.
REQ-011 flush  input  1  kill the instruction in EX this cycle.
REQ-012 result_q  output  WIDTH  registered result to MEM.
REQ-013 valid_q  output  1  registered valid to MEM.
REQ-014 flags_q  output  4  architectural flags {N,Z,V,C}.
REQ-015 branch_taken_q  output  1  registered: instruction in MEM is a taken branch.
REQ-016 squash_active  output  1  high while the state machine is in SQUASH.

Function
REQ-017 "Accept" SHALL mean valid_in & ~stall & ~flush & ~squash_active at a rising edge.
REQ-018 On accept: result_q<=alu_result, valid_q<=1, branch_taken_q<=take (REQ-021); latency exactly one cycle.
REQ-019 Non-stalled edge without accept (flush, squash, or valid_in=0): valid_q<=0, branch_taken_q<=0, result_q holds.
REQ-020 stall=1 and flush=0: result_q, valid_q, branch_taken_q, flags_q, state all hold.
REQ-021 take: B -> 1; CBZ -> alu_zero; B.cond -> cond evaluated on flags_q (current register, pre-update); none -> 0.
REQ-022 Cond evaluation: EQ Z; NE ~Z; HS C; LO ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~(C&~Z); GE N==V; LT N!=V; GT ~Z&(N==V); LE ~(~Z&(N==V)); AL 1.
REQ-023 flags_q<={alu_negative,alu_zero,alu_overflow,alu_carry} only on accept with set_flags=1; otherwise holds.
REQ-024 A flag-setting instruction followed directly by B.cond: the B.cond SHALL see the new flags (register updated one edge earlier; no bypass required).
REQ-025 FSM states NORMAL and SQUASH; NORMAL->SQUASH on accept with take=1; SQUASH->NORMAL on the next edge with stall=0.
REQ-026 In SQUASH with stall=0, the EX instruction SHALL be discarded (no result, no flag update, no branch) regardless of valid_in.
REQ-027 In SQUASH with stall=1, state stays SQUASH; the squash is consumed only on a non-stalled edge.
REQ-028 flush=1 has priority over stall: REQ-019 applies and FSM forces NORMAL.
REQ-029 squash_active SHALL be 1 exactly when state is SQUASH.
REQ-030 Flag outputs of the ALU for non-flag-setting ops SHALL never reach flags_q.

Reset
REQ-031 reset=1 SHALL asynchronously force result_q=0, valid_q=0, branch_taken_q=0, flags_q=4'b0000, state=NORMAL, squash_active=0.
REQ-032 Reset asserted mid-squash or mid-stall SHALL discard the pending squash; first edge after deassert behaves as NORMAL.

Verification
REQ-033 SUBS accept, alu_result=0, flags N0 Z1 V0 C1 -> next cycle flags_q=0101, result_q=0, valid_q=1, branch_taken_q=0.
REQ-034 Flags 0101 then B.cond EQ accept -> branch_taken_q=1, squash_active=1; next instruction (valid_in=1, ADD 5) discarded, valid_q=0, then NORMAL.
REQ-035 Flags N1 V0: B.cond LT -> taken; GE -> not taken; flags N1 V1: GE taken, LT not.
REQ-036 CBZ with alu_zero=0 -> branch_taken_q=0, no squash; CBZ with alu_zero=1 -> taken; flags_q unchanged in both.
REQ-037 Taken B, then stall=1 for 3 cycles -> squash_active stays 1, outputs hold; first unstalled edge discards EX instruction, state NORMAL.
REQ-038 stall=1 and flush=1 together during SQUASH, then reset mid-cycle -> valid_q=0, squash_active=0, flags_q=0000 immediately on reset.

Source files
------------

// File: rtl/ex_flags_stage.sv
// EX->MEM boundary: registers ALU result, owns the NZVC flags and
// resolves branches, squashing the instruction behind a taken branch.
module ex_flags_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_negative,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             alu_carry,
   input  logic             valid_in,
   input  logic             set_flags,
   input  logic [1:0]       br_type,
   input  logic [3:0]       cond,
   input  logic             stall,
   input  logic             flush,
   output logic [WIDTH-1:0] result_q,
   output logic             valid_q,
   output logic [3:0]       flags_q,
   output logic             branch_taken_q,
   output logic             squash_active
);

   typedef enum logic {
      NORMAL = 1'b0,
      SQUASH = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic f_n, f_z, f_v, f_c;
   logic cond_ok;
   logic take;
   logic accept;

   assign {f_n, f_z, f_v, f_c} = flags_q;
   assign squash_active = (state_q == SQUASH);
   assign accept = valid_in & ~stall & ~flush & ~squash_active;

   // B.cond reads the architectural register, never the live ALU flags
   always_comb begin
      cond_ok = 1'b0;
      unique case (cond)
         4'h0: cond_ok = f_z;
         4'h1: cond_ok = ~f_z;
         4'h2: cond_ok = f_c;
         4'h3: cond_ok = ~f_c;
         4'h4: cond_ok = f_n;
         4'h5: cond_ok = ~f_n;
         4'h6: cond_ok = f_v;
         4'h7: cond_ok = ~f_v;
         4'h8: cond_ok = f_c & ~f_z;
         4'h9: cond_ok = ~(f_c & ~f_z);
         4'hA: cond_ok = (f_n == f_v);
         4'hB: cond_ok = (f_n != f_v);
         4'hC: cond_ok = ~f_z & (f_n == f_v);
         4'hD: cond_ok = ~(~f_z & (f_n == f_v));
         4'hE: cond_ok = 1'b1;
         4'hF: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      take = 1'b0;
      unique case (br_type)
         2'b00: take = 1'b0;
         2'b01: take = 1'b1;
         2'b10: take = alu_zero;
         2'b11: take = cond_ok;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = NORMAL;
      end else if (!stall) begin
         unique case (state_q)
            NORMAL: if (accept && take) state_d = SQUASH;
            SQUASH: state_d = NORMAL;
            default: state_d = NORMAL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q       <= '0;
         valid_q        <= 1'b0;
         branch_taken_q <= 1'b0;
         flags_q        <= 4'b0000;
      end else if (flush || !stall) begin
         valid_q        <= accept;
         branch_taken_q <= accept & take;
         if (accept) begin
            result_q <= alu_result;
         end
         if (accept && set_flags) begin
            flags_q <= {alu_negative, alu_zero,
                        alu_overflow, alu_carry};
         end
      end
   end

endmodule

// File: tb/tb_ex_flags_stage.sv
// Directed bench for ex_flags_stage: reference model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ex_flags_stage;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  alu_result = '0;
   logic          alu_negative = 1'b0;
   logic          alu_zero = 1'b0;
   logic          alu_overflow = 1'b0;
   logic          alu_carry = 1'b0;
   logic          valid_in = 1'b0;
   logic          set_flags = 1'b0;
   logic [1:0]    br_type = 2'b00;
   logic [3:0]    cond = 4'h0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic [W-1:0]  result_q;
   logic          valid_q;
   logic [3:0]    flags_q;
   logic          branch_taken_q;
   logic          squash_active;

   int passed = 0;
   int total = 0;
   bit cmp_on = 1'b0;

   ex_flags_stage #(.WIDTH(W)) dut (
      .clk(clk),
      .reset(reset),
      .alu_result(alu_result),
      .alu_negative(alu_negative),
      .alu_zero(alu_zero),
      .alu_overflow(alu_overflow),
      .alu_carry(alu_carry),
      .valid_in(valid_in),
      .set_flags(set_flags),
      .br_type(br_type),
      .cond(cond),
      .stall(stall),
      .flush(flush),
      .result_q(result_q),
      .valid_q(valid_q),
      .flags_q(flags_q),
      .branch_taken_q(branch_taken_q),
      .squash_active(squash_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Condition = base predicate selected by cond[3:1], inverted by cond[0]
   function automatic logic cond_holds(input logic [3:0] c,
                                       input logic [3:0] nzvc);
      logic n, z, v, cc, r;
      {n, z, v, cc} = nzvc;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cc;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cc && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: return 1'b1;
      endcase
      return c[0] ? !r : r;
   endfunction

   function automatic logic br_taken(input logic [1:0] bt,
                                     input logic [3:0] c,
                                     input logic [3:0] nzvc,
                                     input logic zf);
      if (bt == 2'd1) return 1'b1;
      if (bt == 2'd2) return zf;
      if (bt == 2'd3) return cond_holds(c, nzvc);
      return 1'b0;
   endfunction

   logic [W-1:0] m_result;
   logic         m_valid;
   logic [3:0]   m_flags;
   logic         m_br;
   logic         m_sq;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_result <= '0;
         m_valid  <= 1'b0;
         m_flags  <= 4'b0;
         m_br     <= 1'b0;
         m_sq     <= 1'b0;
      end else if (flush) begin
         m_valid <= 1'b0;
         m_br    <= 1'b0;
         m_sq    <= 1'b0;
      end else if (!stall) begin
         if (m_sq || !valid_in) begin
            m_valid <= 1'b0;
            m_br    <= 1'b0;
            m_sq    <= 1'b0;
         end else begin
            m_result <= alu_result;
            m_valid  <= 1'b1;
            m_br     <= br_taken(br_type, cond, m_flags, alu_zero);
            m_sq     <= br_taken(br_type, cond, m_flags, alu_zero);
            if (set_flags)
               m_flags <= {alu_negative, alu_zero,
                           alu_overflow, alu_carry};
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("result_q", result_q, m_result);
         chk("valid_q", 64'(valid_q), 64'(m_valid));
         chk("flags_q", 64'(flags_q), 64'(m_flags));
         chk("branch_taken_q", 64'(branch_taken_q), 64'(m_br));
         chk("squash_active", 64'(squash_active), 64'(m_sq));
      end
   end

   // One EX slot; returns 2 time units after the rising edge
   task automatic cyc(input logic v, input logic sf,
                      input logic [1:0] bt, input logic [3:0] c,
                      input logic [63:0] r, input logic [3:0] nzvc,
                      input logic st, input logic fl);
      valid_in  = v;
      set_flags = sf;
      br_type   = bt;
      cond      = c;
      alu_result = r;
      {alu_negative, alu_zero, alu_overflow, alu_carry} = nzvc;
      stall = st;
      flush = fl;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 2'd0, 4'h0, 64'h0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      cmp_on = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst valid_q", 64'(valid_q), 64'd0);
      chk("rst flags_q", 64'(flags_q), 64'd0);
      chk("rst squash", 64'(squash_active), 64'd0);
      reset = 1'b0;
      idle();

      // SUBS giving zero, N0 Z1 V0 C1
      cyc(1, 1, 2'd0, 4'h0, 64'h0, 4'b0101, 0, 0);
      chk("subs flags", 64'(flags_q), 64'h5);
      chk("subs valid", 64'(valid_q), 64'd1);
      chk("subs br", 64'(branch_taken_q), 64'd0);

      // B.EQ taken; ALU flags on it must not leak into flags_q
      cyc(1, 0, 2'd3, 4'h0, 64'h100, 4'b1010, 0, 0);
      chk("beq taken", 64'(branch_taken_q), 64'd1);
      chk("beq squash", 64'(squash_active), 64'd1);
      chk("beq flags", 64'(flags_q), 64'h5);
      cyc(1, 0, 2'd0, 4'h0, 64'h5, 4'h0, 0, 0);
      chk("shadow valid", 64'(valid_q), 64'd0);
      chk("shadow result", result_q, 64'h100);
      chk("shadow normal", 64'(squash_active), 64'd0);

      // N1 V0: LT taken, GE not
      cyc(1, 1, 2'd0, 4'h0, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1000, 0, 0);
      cyc(1, 0, 2'd3, 4'hB, 64'h1, 4'h0, 0, 0);
      chk("lt n1v0", 64'(branch_taken_q), 64'd1);
      idle();
      cyc(1, 0, 2'd3, 4'hA, 64'h2, 4'h0, 0, 0);
      chk("ge n1v0", 64'(branch_taken_q), 64'd0);

      // N1 V1: GE taken, LT not
      cyc(1, 1, 2'd0, 4'h0, 64'h7, 4'b1010, 0, 0);
      cyc(1, 0, 2'd3, 4'hA, 64'h3, 4'h0, 0, 0);
      chk("ge n1v1", 64'(branch_taken_q), 64'd1);
      idle();
      cyc(1, 0, 2'd3, 4'hB, 64'h4, 4'h0, 0, 0);
      chk("lt n1v1", 64'(branch_taken_q), 64'd0);

      // CBZ both ways, flags untouched
      cyc(1, 0, 2'd2, 4'h0, 64'h9, 4'b0000, 0, 0);
      chk("cbz nz br", 64'(branch_taken_q), 64'd0);
      chk("cbz nz sq", 64'(squash_active), 64'd0);
      cyc(1, 0, 2'd2, 4'h0, 64'h0, 4'b0100, 0, 0);
      chk("cbz z br", 64'(branch_taken_q), 64'd1);
      chk("cbz flags", 64'(flags_q), 64'hA);
      idle();

      // Sweep every cond code over a few flag values
      for (int f = 0; f < 16; f += 5) begin
         cyc(1, 1, 2'd0, 4'h0, 64'(f), 4'(f), 0, 0);
         for (int c = 0; c < 16; c++) begin
            cyc(1, 0, 2'd3, 4'(c), 64'(c + 32), 4'hF, 0, 0);
            idle();
         end
      end

      // Taken B held by 3 stalls, then shadow discarded
      cyc(1, 0, 2'd1, 4'h0, 64'hB0, 4'h0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 2'd0, 4'h0, 64'hDEAD, 4'hF, 1, 0);
         chk("stall sq", 64'(squash_active), 64'd1);
         chk("stall res", result_q, 64'hB0);
      end
      cyc(1, 1, 2'd0, 4'h0, 64'hDEAD, 4'hF, 0, 0);
      chk("unstall valid", 64'(valid_q), 64'd0);
      chk("unstall sq", 64'(squash_active), 64'd0);
      cyc(1, 0, 2'd0, 4'h0, 64'h55, 4'h0, 0, 0);
      chk("after sq", result_q, 64'h55);

      // Flush alone kills the EX instruction
      cyc(1, 1, 2'd1, 4'h0, 64'h66, 4'h3, 0, 1);
      chk("flush valid", 64'(valid_q), 64'd0);

      // Taken B, stall+flush in SQUASH, then async reset mid-cycle
      cyc(1, 1, 2'd0, 4'h0, 64'h1, 4'b0011, 0, 0);
      cyc(1, 0, 2'd1, 4'h0, 64'h2, 4'h0, 0, 0);
      cyc(1, 1, 2'd0, 4'h0, 64'h3, 4'hF, 1, 1);
      chk("sf sq", 64'(squash_active), 64'd0);
      chk("sf valid", 64'(valid_q), 64'd0);
      cyc(1, 0, 2'd1, 4'h0, 64'h4, 4'h0, 0, 0);
      #1 reset = 1'b1;
      #1;
      chk("arst valid", 64'(valid_q), 64'd0);
      chk("arst sq", 64'(squash_active), 64'd0);
      chk("arst flags", 64'(flags_q), 64'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      cyc(1, 0, 2'd0, 4'h0, 64'h77, 4'h0, 0, 0);
      chk("post rst acc", 64'(valid_q), 64'd1);
      idle();

      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
